// File: rtl/shift_receiver_if.sv
// Serial receive bus: bit stream in, one-word output buffer with valid/ready.
// Ports: i/v/s/dir/qr from the sender side, q/qv/ov/pe back from the receiver.
interface shift_receiver_if;
  logic       i;
  logic       v;
  logic       s;
  logic       dir;
  logic       qr;
  logic [7:0] q;
  logic       qv;
  logic       ov;
  logic       pe;

  modport master (
    output i, v, s, dir, qr,
    input  q, qv, ov, pe
  );

  modport slave (
    input  i, v, s, dir, qr,
    output q, qv, ov, pe
  );
endinterface

// File: rtl/shift_receiver.sv
// Framed serial-to-parallel receiver with a one-word valid/ready output buffer.
// Ports: c (clock), rst (sync, active-high), bus (shift_receiver_if.slave).
// Optional even parity bit per frame: define SHIFT_RECEIVER_PARITY_EN.
module shift_receiver (
  input  logic               c,
  input  logic               rst,
  shift_receiver_if.slave    bus
);

`ifdef SHIFT_RECEIVER_PARITY_EN
  typedef enum logic [1:0] {HUNT, DATA, PAR} state_t;
`else
  typedef enum logic [1:0] {HUNT, DATA} state_t;
`endif

  state_t     st;
  logic [3:0] cnt;
  logic [7:0] w;
  logic       dm;
  logic [7:0] q_r;
  logic       qv_r;
  logic       ov_r;
  logic       pe_r;

  logic       start;
  logic [7:0] shv;
  logic [7:0] stv;
  logic       done;
  logic [7:0] word;
  logic       perr;

  assign start = bus.v && bus.s;
  // frame order is fixed by the direction latched at frame start
  assign shv = dm ? {w[6:0], bus.i} : {bus.i, w[7:1]};
  assign stv = bus.dir ? {7'b0, bus.i} : {bus.i, 7'b0};

  always_comb begin
    done = 1'b0;
    word = shv;
    perr = 1'b0;
    if (bus.v && !bus.s) begin
      unique case (st)
`ifdef SHIFT_RECEIVER_PARITY_EN
        PAR: begin
          done = 1'b1;
          word = w;
          perr = ^w ^ bus.i;
        end
`else
        DATA: done = (cnt == 4'd7);
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge c) begin
    if (rst) begin
      st   <= HUNT;
      cnt  <= 4'd0;
      w    <= 8'h00;
      dm   <= 1'b0;
      q_r  <= 8'h00;
      qv_r <= 1'b0;
      ov_r <= 1'b0;
      pe_r <= 1'b0;
    end else begin
      if (start) begin
        st  <= DATA;
        dm  <= bus.dir;
        w   <= stv;
        cnt <= 4'd1;
      end else if (bus.v) begin
        unique case (st)
          DATA: begin
            w   <= shv;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
`ifdef SHIFT_RECEIVER_PARITY_EN
              st <= PAR;
`else
              st <= HUNT;
`endif
            end
          end
`ifdef SHIFT_RECEIVER_PARITY_EN
          PAR: begin
            st  <= HUNT;
            cnt <= 4'd0;
          end
`endif
          default: ;
        endcase
      end

      // a full buffer being drained this edge can accept the new word
      if (done && (!qv_r || bus.qr)) begin
        q_r  <= word;
        qv_r <= 1'b1;
        pe_r <= perr;
      end else if (done) begin
        ov_r <= 1'b1;
      end else if (qv_r && bus.qr) begin
        qv_r <= 1'b0;
      end
    end
  end

  assign bus.q  = q_r;
  assign bus.qv = qv_r;
  assign bus.ov = ov_r;
  assign bus.pe = pe_r;

endmodule

// File: tb/tb_shift_receiver.sv
// Directed bench for shift_receiver.
// Drives framed bit streams and checks the output buffer after each step.
module tb_shift_receiver;
  logic c;
  logic rst;
  int   vectors;
  int   miscompares;

  shift_receiver_if bus ();

  shift_receiver dut (
    .c   (c),
    .rst (rst),
    .bus (bus)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eq,
                         input logic eqv, input logic eov,
                         input logic epe);
    chk({tag, ".q"}, bus.q, eq);
    chk({tag, ".qv"}, {7'b0, bus.qv}, {7'b0, eqv});
    chk({tag, ".ov"}, {7'b0, bus.ov}, {7'b0, eov});
    chk({tag, ".pe"}, {7'b0, bus.pe}, {7'b0, epe});
  endtask

  task automatic send_bit(input logic b, input logic st,
                          input logic d, input logic r);
    bus.i = b; bus.s = st; bus.dir = d; bus.v = 1'b1; bus.qr = r;
    @(posedge c); #1;
    bus.v = 1'b0; bus.s = 1'b0; bus.qr = 1'b0;
  endtask

  task automatic idle(input logic r);
    bus.v = 1'b0; bus.qr = r;
    @(posedge c); #1;
    bus.qr = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic d,
                           input int lo, input int hi,
                           input logic gap, input logic lr);
    for (int k = lo; k <= hi; k++) begin
      logic [7:0] bb;
      int idx;
      bb = b;
      idx = d ? 7 - k : k;
      send_bit(bb[idx], k == 0, d, k == hi ? lr : 1'b0);
      if (gap && k < hi) idle(1'b0);
    end
  endtask

  task automatic finish_frame(input logic [7:0] b, input logic lr);
`ifdef SHIFT_RECEIVER_PARITY_EN
    send_bit(^b, 1'b0, 1'b0, lr);
`else
    if (lr) ;
    if (b == 8'h00) ;
`endif
  endtask

  task automatic send_frame(input logic [7:0] b, input logic d,
                            input logic gap, input logic lr);
`ifdef SHIFT_RECEIVER_PARITY_EN
    send_bits(b, d, 0, 7, gap, 1'b0);
    send_bit(^b, 1'b0, d, lr);
`else
    send_bits(b, d, 0, 7, gap, lr);
`endif
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    bus.i = 0; bus.v = 0; bus.s = 0; bus.dir = 0; bus.qr = 0;
    rst = 1'b1;
    @(posedge c); #1;
    @(posedge c); #1;
    rst = 1'b0;
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // LSB-first A5, check latency before last bit
    send_bits(8'hA5, 1'b0, 0, 6, 1'b0, 1'b0);
    chk("lsb_pre.qv", {7'b0, bus.qv}, 8'h00);
`ifdef SHIFT_RECEIVER_PARITY_EN
    send_bits(8'hA5, 1'b0, 7, 7, 1'b0, 1'b0);
    chk("lsb_prepar.qv", {7'b0, bus.qv}, 8'h00);
`else
    send_bits(8'hA5, 1'b0, 7, 7, 1'b0, 1'b0);
`endif
    finish_frame(8'hA5, 1'b0);
    chk_all("lsb_a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("consume1.qv", {7'b0, bus.qv}, 8'h00);

    // MSB-first A5, then gapped 3C drained around consumption
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    chk_all("msb_a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    send_bits(8'h3C, 1'b1, 0, 3, 1'b1, 1'b0);
    chk("gap_hold.q", bus.q, 8'hA5);
    idle(1'b1);
    chk("gap_cons.qv", {7'b0, bus.qv}, 8'h00);
    send_bits(8'h3C, 1'b1, 4, 7, 1'b1, 1'b0);
    finish_frame(8'h3C, 1'b0);
    chk_all("msb_3c", 8'h3C, 1'b1, 1'b0, 1'b0);
    idle(1'b1);

    // overrun: second word dropped, flag sticky
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    chk_all("overrun", 8'h11, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    chk("ovr_cons.qv", {7'b0, bus.qv}, 8'h00);
    chk("ovr_sticky", {7'b0, bus.ov}, 8'h01);
    idle(1'b0);
    chk("ovr_sticky2", {7'b0, bus.ov}, 8'h01);

    // completion on the consuming edge
    rst = 1'b1; idle(1'b0); rst = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    chk_all("same_edge", 8'h55, 1'b1, 1'b0, 1'b0);
    idle(1'b1);

    // resync after a partial frame
    send_bits(8'hFF, 1'b0, 0, 2, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    chk_all("resync", 8'hF0, 1'b1, 1'b0, 1'b0);

    // reset mid-frame wins over a simultaneous start bit
    send_bits(8'hAA, 1'b0, 0, 3, 1'b0, 1'b0);
    rst = 1'b1;
    send_bit(1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    chk_all("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
    send_bits(8'hAA, 1'b0, 1, 7, 1'b0, 1'b0);
    finish_frame(8'hAA, 1'b0);
    chk("hunt_ign.qv", {7'b0, bus.qv}, 8'h00);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    chk_all("post_rst", 8'h81, 1'b1, 1'b0, 1'b0);
    idle(1'b1);

`ifdef SHIFT_RECEIVER_PARITY_EN
    send_bits(8'h07, 1'b0, 0, 7, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("par_ok", 8'h07, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    send_bits(8'h07, 1'b0, 0, 7, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("par_bad", 8'h07, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
